// File: rtl/pipe_ex_feeder.sv
// rtl/pipe_ex_feeder.sv - operand/result buffering with credit-based issue around pipe_ex
module pipe_ex_feeder #(
    parameter int N      = 10,
    parameter int IDEPTH = 8,
    parameter int RDEPTH = 8,
    parameter int LAT    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_a,
    input  logic [N-1:0]           in_b,
    input  logic [N-1:0]           in_c,
    input  logic [N-1:0]           in_d,
    output logic [N-1:0]           pa,
    output logic [N-1:0]           pb,
    output logic [N-1:0]           pc,
    output logic [N-1:0]           pd,
    output logic                   p_issue,
    input  logic [N-1:0]           pf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_f,
    output logic [$clog2(LAT+1):0] inflight,
    output logic                   busy
);
    localparam int IAW = $clog2(IDEPTH);
    localparam int RAW = $clog2(RDEPTH);
    localparam int IFW = $clog2(LAT+1) + 1;

    logic [4*N-1:0] imem_q [IDEPTH];
    logic [N-1:0]   rmem_q [RDEPTH];

    logic [IAW:0]   iwr_q, iwr_d, ird_q, ird_d;
    logic [RAW:0]   rwr_q, rwr_d, rrd_q, rrd_d, rcount;
    logic [IFW-1:0] inflight_q, inflight_d;
    logic [LAT-1:0] vld_q, vld_d;
    logic [N-1:0]   pa_q, pa_d, pb_q, pb_d, pc_q, pc_d, pd_q, pd_d;
    logic           p_issue_q, ready_q;

    logic ifull, iempty, rfull, rempty, credit_ok;
    logic push_in, issue, cap, pop_out;

    assign iempty    = (iwr_q == ird_q);
    assign ifull     = (iwr_q[IAW] != ird_q[IAW]) && (iwr_q[IAW-1:0] == ird_q[IAW-1:0]);
    assign rcount    = rwr_q - rrd_q;
    assign rempty    = (rcount == '0);
    assign rfull     = (rcount == (RAW+1)'(RDEPTH));
    // Results already stored plus results still in the pipe must fit the result FIFO.
    assign credit_ok = (32'(rcount) + 32'(inflight_q)) < 32'(RDEPTH);

    // ready_q gives the synchronous release: the host is accepted one cycle after rst_n rises.
    assign in_ready  = ready_q && !ifull;
    assign push_in   = in_valid && in_ready;
    assign issue     = !iempty && credit_ok;
    assign cap       = vld_q[LAT-1];
    assign out_valid = !rempty;
    assign pop_out   = out_valid && out_ready;

    assign pa        = pa_q;
    assign pb        = pb_q;
    assign pc        = pc_q;
    assign pd        = pd_q;
    assign p_issue   = p_issue_q;
    assign inflight  = inflight_q;
    assign out_f     = rempty ? '0 : rmem_q[rrd_q[RAW-1:0]];
    assign busy      = !iempty || !rempty || (inflight_q != '0);

    always_comb begin
        iwr_d      = iwr_q + (IAW+1)'(push_in);
        ird_d      = ird_q + (IAW+1)'(issue);
        rwr_d      = rwr_q + (RAW+1)'(cap);
        rrd_d      = rrd_q + (RAW+1)'(pop_out);
        inflight_d = inflight_q + IFW'(issue) - IFW'(cap);
        vld_d      = (vld_q << 1) | LAT'(p_issue_q);
        pa_d       = pa_q;
        pb_d       = pb_q;
        pc_d       = pc_q;
        pd_d       = pd_q;
        if (issue) begin
            {pa_d, pb_d, pc_d, pd_d} = imem_q[ird_q[IAW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iwr_q      <= '0;
            ird_q      <= '0;
            rwr_q      <= '0;
            rrd_q      <= '0;
            inflight_q <= '0;
            vld_q      <= '0;
            pa_q       <= '0;
            pb_q       <= '0;
            pc_q       <= '0;
            pd_q       <= '0;
            p_issue_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            iwr_q      <= iwr_d;
            ird_q      <= ird_d;
            rwr_q      <= rwr_d;
            rrd_q      <= rrd_d;
            inflight_q <= inflight_d;
            vld_q      <= vld_d;
            pa_q       <= pa_d;
            pb_q       <= pb_d;
            pc_q       <= pc_d;
            pd_q       <= pd_d;
            p_issue_q  <= issue;
            ready_q    <= 1'b1;
        end
    end

    // Storage arrays carry no reset; the pointers alone define their contents.
    always_ff @(posedge clk) begin
        if (push_in) begin
            imem_q[iwr_q[IAW-1:0]] <= {in_a, in_b, in_c, in_d};
        end
        if (cap) begin
            rmem_q[rwr_q[RAW-1:0]] <= pf;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(cap && rfull && !pop_out));

endmodule

// File: tb/tb_pipe_ex_feeder.sv
// tb/tb_pipe_ex_feeder.sv - randomized scoreboard bench for pipe_ex_feeder with a pipe_ex model
module tb_pipe_ex_feeder;
    localparam int N      = 10;
    localparam int IDEPTH = 8;
    localparam int RDEPTH = 8;
    localparam int LAT    = 3;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] c;
        logic [N-1:0] d;
    } tup_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   in_valid, in_ready;
    logic [N-1:0]           in_a, in_b, in_c, in_d;
    logic [N-1:0]           pa, pb, pc, pd, pf, out_f;
    logic                   p_issue, out_valid, out_ready, busy;
    logic [$clog2(LAT+1):0] inflight;

    pipe_ex_feeder #(.N(N), .IDEPTH(IDEPTH), .RDEPTH(RDEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .pa(pa), .pb(pb), .pc(pc), .pd(pd), .p_issue(p_issue),
        .pf(pf),
        .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
        .inflight(inflight), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [N-1:0] f_of(input tup_t t);
        int v;
        v = ((int'(t.a) + int'(t.b)) + (int'(t.c) - int'(t.d))) * int'(t.d);
        return v[N-1:0];
    endfunction

    function automatic tup_t mk(input int a, input int b, input int c, input int d);
        tup_t t;
        t.a = N'(a);
        t.b = N'(b);
        t.c = N'(c);
        t.d = N'(d);
        return t;
    endfunction

    function automatic tup_t rnd_tup();
        return mk($urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 1023), $urandom_range(0, 1023));
    endfunction

    // pipe_ex: F of the operands presented LAT cycles earlier.
    logic [N-1:0] hist [LAT];
    always @(posedge clk) begin
        hist[0] <= f_of({pa, pb, pc, pd});
        for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
    end
    assign pf = hist[LAT-1];

    // Host sender: holds the head tuple until it is accepted.
    tup_t sendq[$];
    bit   took;
    initial begin
        in_valid = 1'b0;
        {in_a, in_b, in_c, in_d} = '0;
        forever begin
            @(negedge clk);
            took = in_valid && in_ready && rst_n;
            @(posedge clk);
            #1;
            if (took && sendq.size() > 0) void'(sendq.pop_front());
            if (!rst_n) sendq.delete();
            if (sendq.size() > 0) begin
                in_valid = 1'b1;
                {in_a, in_b, in_c, in_d} = sendq[0];
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    // Reference model: accepted-not-issued queue, issued-not-returned queue, issue window.
    tup_t         acc_q[$];
    logic [N-1:0] res_q[$];
    int           win_q[$];
    tup_t         last_t;
    int           since, infl_m, rc_m, cyc;
    bit           exp_ok, exp_iss;
    int           iss_cyc[$];
    logic [N-1:0] out_log[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("rst_operands", {pa, pb, pc, pd}, 0);
            check("rst_p_issue", p_issue, 0);
            check("rst_inflight", inflight, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_f", out_f, 0);
            check("rst_busy", busy, 0);
            acc_q.delete();
            res_q.delete();
            win_q.delete();
            last_t = '0;
            since  = 0;
            exp_ok = 1'b0;
        end else begin
            since++;
            if (exp_ok) check("issue_rule", p_issue, exp_iss);
            if (p_issue) begin
                iss_cyc.push_back(cyc);
                check("issue_avail", acc_q.size() > 0, 1);
                if (acc_q.size() > 0) begin
                    check("issue_tuple", {pa, pb, pc, pd}, acc_q[0]);
                    last_t = acc_q.pop_front();
                    res_q.push_back(f_of(last_t));
                end
            end else begin
                check("operand_hold", {pa, pb, pc, pd}, last_t);
            end
            win_q.push_back(int'(p_issue));
            if (win_q.size() > LAT + 1) void'(win_q.pop_front());
            infl_m = 0;
            foreach (win_q[i]) infl_m += win_q[i];
            rc_m = res_q.size() - infl_m;
            check("inflight", inflight, infl_m);
            check("out_valid", out_valid, rc_m > 0);
            if (rc_m > 0) check("out_f", out_f, res_q[0]);
            check("busy", busy, (acc_q.size() > 0) || (res_q.size() > 0));
            check("in_ready", in_ready, (since > 1) && (acc_q.size() < IDEPTH));
            check("credit", res_q.size() <= RDEPTH, 1);
            exp_iss = (acc_q.size() > 0) && (res_q.size() < RDEPTH);
            exp_ok  = 1'b1;
            if (in_valid && in_ready) acc_q.push_back({in_a, in_b, in_c, in_d});
            if (out_valid && out_ready) begin
                out_log.push_back(out_f);
                if (res_q.size() > 0) void'(res_q.pop_front());
            end
        end
    end

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while ((sendq.size() != 0 || in_valid || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_within_budget", k < budget, 1);
    endtask

    task automatic clear_logs();
        iss_cyc.delete();
        out_log.delete();
    endtask

    logic [N-1:0] exp2 [8];
    int k;

    initial begin
        exp2 = '{75, 66, 112, 62, 0, 96, 59, 116};
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single tuple
        @(posedge clk); #1;
        out_ready = 1'b1;
        clear_logs();
        sendq.push_back(mk(10, 12, 6, 3));
        k = 0;
        @(negedge clk);
        while (!p_issue && k < 20) begin @(negedge clk); k++; end
        check("t1_issue_seen", p_issue, 1);
        check("t1_operands", {pa, pb, pc, pd}, mk(10, 12, 6, 3));
        check("t1_inflight_1", inflight, 1);
        k = 1;
        @(negedge clk);
        while (!out_valid && k < 20) begin @(negedge clk); k++; end
        check("t1_latency", k, LAT + 1);
        check("t1_out_f", out_f, 75);
        check("t1_inflight_0", inflight, 0);
        wait_idle(50);

        // Burst of 8
        clear_logs();
        sendq.push_back(mk(10, 12, 6, 3));
        sendq.push_back(mk(10, 10, 5, 3));
        sendq.push_back(mk(20, 11, 1, 4));
        sendq.push_back(mk(15, 10, 8, 2));
        sendq.push_back(mk(8, 15, 5, 0));
        sendq.push_back(mk(10, 20, 5, 3));
        sendq.push_back(mk(10, 20, 30, 1));
        sendq.push_back(mk(30, 1, 2, 4));
        wait_idle(100);
        check("t2_issue_count", iss_cyc.size(), 8);
        if (iss_cyc.size() == 8) check("t2_back_to_back", iss_cyc[7] - iss_cyc[0], 7);
        check("t2_out_count", out_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < out_log.size()) check("t2_out_value", out_log[i], exp2[i]);
        end

        // Backpressure: 12 tuples, results blocked
        @(posedge clk); #1;
        out_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 12; i++) sendq.push_back(rnd_tup());
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("t3_issued", iss_cyc.size(), RDEPTH);
        check("t3_in_ready", in_ready, 1);
        check("t3_all_accepted", sendq.size(), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle(200);
        check("t3_drained", out_log.size(), 12);

        // Operand FIFO full: 17th tuple must wait
        @(posedge clk); #1;
        out_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 17; i++) sendq.push_back(rnd_tup());
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("t4_issued", iss_cyc.size(), RDEPTH);
        check("t4_in_ready_low", in_ready, 0);
        check("t4_held_valid", in_valid, 1);
        check("t4_held_pending", sendq.size(), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle(300);
        check("t4_drained", out_log.size(), 17);

        // Reset mid-burst with three tuples in flight
        for (int i = 0; i < 6; i++) sendq.push_back(rnd_tup());
        k = 0;
        @(negedge clk);
        while (inflight != 3 && k < 30) begin @(negedge clk); k++; end
        check("t5_inflight_3", inflight, 3);
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_operands", {pa, pb, pc, pd}, 0);
        check("t5_async_p_issue", p_issue, 0);
        check("t5_async_inflight", inflight, 0);
        check("t5_async_out_valid", out_valid, 0);
        check("t5_async_busy", busy, 0);
        clear_logs();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t5_no_stale_capture", out_log.size(), 0);
        check("t5_out_valid_low", out_valid, 0);

        // Randomized traffic with phases of heavy result backpressure
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            if (sendq.size() < 2 && $urandom_range(0, 2) != 0) sendq.push_back(rnd_tup());
            if ((i % 300) < 120) out_ready = ($urandom_range(0, 7) == 0);
            else                 out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual cycle %0d, required completion before 50000", cyc);
        $fatal(1);
    end

endmodule
